// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register slave: FSM states, command
// bit position and SCK edge selection per SPI mode.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_e;

    function automatic int cmd_wr_bit(input int data_w);
        return data_w - 1;
    endfunction

    // Returns {sample, shift} strobes; leading edge is the move away from CPOL.
    function automatic logic [1:0] edge_sel(input logic cpol, input logic cpha,
                                            input logic rise, input logic fall);
        logic lead;
        logic trail;
        lead  = cpol ? fall : rise;
        trail = cpol ? rise : fall;
        return cpha ? {trail, lead} : {lead, trail};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser plus an edge register; rise/fall pulses are one clk wide,
// valid 2 clk after the pin changes and acted on by the 3rd edge. No backpressure.
module spi_sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], din_i};
        end
    end

    assign rise_o =  sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave (all four modes) with an addressed, auto-incrementing register bank.
// Write lands 4 clk after the last sample edge on the pin; the master is never stalled.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               NUM_REGS  = 4,
    parameter bit               CPOL      = 1'b0,
    parameter bit               CPHA      = 1'b0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DATA_W-1:0] ID_WORD   = DATA_W'(8'hA5),
    localparam int              ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sck,
    input  logic                       ssel,
    input  logic                       mosi,
    output logic                       miso,
    output logic                       miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int WR_BIT = cmd_wr_bit(DATA_W);

    logic sck_rise, sck_fall, ssel_rise, ssel_fall;
    logic [1:0] mosi_sync_q;
    logic       mosi_s;
    logic [1:0] edges;
    logic       sample_stb, shift_stb, last_bit;

    state_e state_q, state_d;
    logic                               selected;
    logic [CNT_W-1:0]                   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]                  rx_q, rx_d;
    logic [DATA_W-1:0]                  rx_shift;
    logic [DATA_W-1:0]                  tx_q, tx_d;
    logic [ADDR_W-1:0]                  addr_q, addr_d, addr_inc;
    logic                               wr_mode_q, wr_mode_d;
    logic                               wpend_q, wpend_d;
    logic [DATA_W-1:0]                  wdata_q, wdata_d;
    logic [ADDR_W-1:0]                  waddr_q, waddr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
    logic                               wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]                  wr_addr_q, wr_addr_d;
    logic                               miso_q, miso_d;
    logic                               miso_oe_q, miso_oe_d;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ssel_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (ssel),
        .rise_o (ssel_rise),
        .fall_o (ssel_fall)
    );

    assign mosi_s     = mosi_sync_q[1];
    assign edges      = edge_sel(CPOL, CPHA, sck_rise, sck_fall);
    assign sample_stb = edges[1];
    assign shift_stb  = edges[0];
    assign last_bit   = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign rx_shift   = {rx_q, mosi_s};
    assign addr_inc   = addr_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ssel_rise) begin
            state_d = S_IDLE;
        end else if (ssel_fall) begin
            state_d = S_CMD;
        end else if (state_q == S_CMD && sample_stb && last_bit) begin
            state_d = S_DATA;
        end
    end

    always_comb begin
        selected  = (state_q != S_IDLE);
        miso_oe_d = selected;
        miso_d    = selected ? tx_q[DATA_W-1] : 1'b0;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_mode_d = wr_mode_q;
        wpend_d   = 1'b0;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        regs_d    = regs_q;
        wr_stb_d  = wpend_q;
        wr_addr_d = wr_addr_q;

        if (wpend_q) begin
            regs_d[waddr_q] = wdata_q;
            wr_addr_d       = waddr_q;
        end

        if (ssel_fall) begin
            bit_cnt_d = '0;
            tx_d      = ID_WORD;
        end else if (ssel_rise) begin
            // A partial word is simply dropped; completed words already committed.
            bit_cnt_d = '0;
        end else if (selected) begin
            if (sample_stb) begin
                rx_d = rx_shift[DATA_W-2:0];
                if (last_bit) begin
                    bit_cnt_d = '0;
                    if (state_q == S_CMD) begin
                        wr_mode_d = rx_shift[WR_BIT];
                        addr_d    = rx_shift[ADDR_W-1:0];
                        tx_d      = regs_q[rx_shift[ADDR_W-1:0]];
                    end else begin
                        wpend_d = wr_mode_q;
                        wdata_d = rx_shift;
                        waddr_d = addr_q;
                        addr_d  = addr_inc;
                        tx_d    = regs_q[addr_inc];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end else if (shift_stb && bit_cnt_q != '0) begin
                // Count of zero means a fresh word whose MSB is already on miso.
                tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wr_mode_q   <= 1'b0;
            wpend_q     <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wr_mode_q   <= wr_mode_d;
            wpend_q     <= wpend_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    assign reg_out = regs_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign miso    = miso_q;
    assign miso_oe = miso_oe_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench: four slaves (modes 0-3) share one logical SPI master; results are
// compared against a table of hand-computed words and a register-array model.
module tb_spi_reg_slave;

    localparam int HP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       ssel  = 1'b1;
    logic       ph    = 1'b0;
    logic [1:0] mosi_v = 2'b00;
    logic [3:0] sck, miso, miso_oe, wr_stb;
    logic [31:0] reg_out [4];
    logic [1:0]  wr_addr [4];

    int         n_err = 0;
    int         n_chk = 0;
    int         stb_cnt [4] = '{0, 0, 0, 0};
    logic [1:0] last_wa [4];
    int         exp_stb = 0;
    logic [1:0] exp_wa = 2'd0;
    logic [7:0] mreg [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] rxw [4];
    logic [7:0] got [4][4];
    logic [7:0] ew [4];

    for (genvar m = 0; m < 4; m++) begin : g_dut
        assign sck[m] = ph ^ 1'(m / 2);
        spi_reg_slave #(.CPOL(1'(m / 2)), .CPHA(1'(m % 2))) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .sck     (sck[m]),
            .ssel    (ssel),
            .mosi    (mosi_v[m % 2]),
            .miso    (miso[m]),
            .miso_oe (miso_oe[m]),
            .reg_out (reg_out[m]),
            .wr_stb  (wr_stb[m]),
            .wr_addr (wr_addr[m])
        );
    end

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (wr_stb[m] === 1'b1) begin
                stb_cnt[m]++;
                last_wa[m] = wr_addr[m];
            end
        end
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] dat;
        int          nd;
        logic [31:0] exp_miso;
    } vec_t;

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s mode%0d: got %0h expected %0h", nm, m, act, exp);
        end
    endtask

    function automatic logic [31:0] model_bank();
        return {mreg[3], mreg[2], mreg[1], mreg[0]};
    endfunction

    // One word (or a prefix of nbits) MSB first; every drive happens at posedge+1.
    task automatic shift_word(input logic [7:0] tx, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi_v[0] = tx[7-i];
            repeat (HP) @(posedge clk);
            #1;
            rxw[0][7-i] = miso[0];
            rxw[2][7-i] = miso[2];
            ph = 1'b1;
            repeat (HP / 2) @(posedge clk);
            #1;
            mosi_v[1] = tx[7-i];
            repeat (HP / 2) @(posedge clk);
            #1;
            rxw[1][7-i] = miso[1];
            rxw[3][7-i] = miso[3];
            ph = 1'b0;
        end
    endtask

    task automatic check_bank(input string nm);
        for (int m = 0; m < 4; m++) begin
            chk({nm, "_regs"}, m, reg_out[m], model_bank());
            chk({nm, "_stbcnt"}, m, stb_cnt[m], exp_stb);
            if (exp_stb > 0) chk({nm, "_wraddr"}, m, {30'd0, last_wa[m]}, {30'd0, exp_wa});
        end
    endtask

    task automatic frame(input logic [7:0] c, input logic [23:0] d, input int nd);
        logic [1:0] idx;
        ew[0] = 8'hA5;
        for (int j = 0; j < nd; j++) begin
            idx = c[1:0] + 2'(j);
            ew[j+1] = mreg[idx];
            if (c[7]) begin
                mreg[idx] = d[23-8*j -: 8];
                exp_stb++;
                exp_wa = idx;
            end
        end
        ssel = 1'b0;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 4; m++) chk("oe_early", m, miso_oe[m], 1'b0);
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk("oe_sel", m, miso_oe[m], 1'b1);
            chk("id_msb", m, miso[m], 1'b1);
        end
        @(posedge clk);
        #1;
        shift_word(c, 8);
        for (int m = 0; m < 4; m++) got[m][0] = rxw[m];
        for (int j = 0; j < nd; j++) begin
            shift_word(d[23-8*j -: 8], 8);
            for (int m = 0; m < 4; m++) got[m][j+1] = rxw[m];
        end
        repeat (HP) @(posedge clk);
        #1;
        ssel = 1'b1;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 4; m++) chk("oe_hold", m, miso_oe[m], 1'b1);
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk("oe_desel", m, miso_oe[m], 1'b0);
            chk("miso_desel", m, miso[m], 1'b0);
        end
        repeat (4) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++)
            for (int k = 0; k <= nd; k++)
                chk($sformatf("miso_w%0d", k), m, got[m][k], ew[k]);
        check_bank("frame");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        logic [7:0]  c;
        logic [23:0] d;
        int          nd;

        tbl[0] = '{8'h81, 24'h3C0000, 1, 32'hA5000000};
        tbl[1] = '{8'h83, 24'h112200, 2, 32'hA5000000};
        tbl[2] = '{8'h03, 24'h000000, 2, 32'hA5112200};
        tbl[3] = '{8'h82, 24'hC30000, 1, 32'hA5000000};
        tbl[4] = '{8'h02, 24'h000000, 1, 32'hA5C30000};
        tbl[5] = '{8'h01, 24'h000000, 1, 32'hA53C0000};
        tbl[6] = '{8'h7D, 24'h000000, 3, 32'hA53CC311};

        repeat (4) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk("rst_regs", m, reg_out[m], 32'h0);
            chk("rst_oe", m, miso_oe[m], 1'b0);
            chk("rst_miso", m, miso[m], 1'b0);
            chk("rst_stb", m, wr_stb[m], 1'b0);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int t = 0; t < 7; t++) begin
            frame(tbl[t].cmd, tbl[t].dat, tbl[t].nd);
            for (int m = 0; m < 4; m++)
                for (int k = 0; k <= tbl[t].nd; k++)
                    chk($sformatf("tbl%0d_w%0d", t, k), m, got[m][k], tbl[t].exp_miso[31-8*k -: 8]);
        end

        for (int r = 0; r < 24; r++) begin
            c  = 8'($urandom);
            d  = 24'($urandom);
            nd = $urandom_range(1, 3);
            frame(c, d, nd);
        end

        // Abort: command then 5 bits of data, deselect; nothing may be written.
        ssel = 1'b0;
        repeat (HP) @(posedge clk);
        #1;
        shift_word(8'h80, 8);
        shift_word(8'hFF, 5);
        repeat (HP) @(posedge clk);
        #1;
        ssel = 1'b1;
        repeat (HP) @(posedge clk);
        #1;
        check_bank("abort");
        for (int m = 0; m < 4; m++) chk("abort_oe", m, miso_oe[m], 1'b0);
        frame(8'h80, 24'h5A0000, 1);
        frame(8'h00, 24'h000000, 2);

        // Reset in the middle of a data word.
        frame(8'h82, 24'h6B0000, 1);
        ssel = 1'b0;
        repeat (HP) @(posedge clk);
        #1;
        shift_word(8'h80, 8);
        shift_word(8'hFF, 3);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk("mrst_regs", m, reg_out[m], 32'h0);
            chk("mrst_oe", m, miso_oe[m], 1'b0);
            chk("mrst_miso", m, miso[m], 1'b0);
            chk("mrst_stb", m, wr_stb[m], 1'b0);
        end
        ssel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check_bank("after_rst");
        frame(8'h81, 24'h770000, 1);
        frame(8'h00, 24'h000000, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
